// File: rtl/ncc_pkg.sv
// ncc_pkg: shared types and helpers for the NCC descriptor datapath.
//   LOG_INT / LOG_FRAC / LOG_W : log2-domain word geometry, [5:-27] = 33 bits.
//   log2_t                     : {sign, exp[4:0], frac[26:0]}.
//   ld_state_t                 : descriptor loader FSM states.
//   to_log2(p)                 : unsigned pixel -> log2_t.
//     p > 0 : exp  = floor(log2 p),
//             frac = the bits below the leading one, left-justified and
//                    zero-filled (truncated if more than 27 such bits).
//     p = 0 : all-zero word, identical to p = 1 (no zero flag).
//     sign is always 0 because pixels are unsigned.
package ncc_pkg;

    localparam int LOG_INT  = 5;
    localparam int LOG_FRAC = 27;
    localparam int LOG_W    = LOG_INT + LOG_FRAC + 1;

    typedef logic [LOG_INT:-LOG_FRAC] log2_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } ld_state_t;

    function automatic log2_t to_log2(input logic [31:0] p);
        int                    e;
        logic [LOG_FRAC-1:0]   frac;
        e = 0;
        for (int i = 0; i < 32; i++) begin
            if (p[i]) e = i;
        end
        // Normalise the leading one to bit 31, then drop it: after >>4 it
        // lands on bit 27, just above the 27-bit fraction field.
        frac = LOG_FRAC'((p << (31 - e)) >> 4);
        return {1'b0, 5'(e), frac};
    endfunction

endpackage

// File: rtl/ncc_pixel_log2.sv
// pixel_log2: leading-one detector + normaliser for one pixel lane.
//   PIX_W   : unsigned pixel width (1..31)
//   pix     : in  unsigned pixel
//   log_val : out log2-domain value (combinational)
import ncc_pkg::*;

module pixel_log2 #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] pix,
    output log2_t            log_val
);

    assign log_val = to_log2(32'(pix));

endmodule

// File: rtl/ncc_desc_loader.sv
// ncc_desc_loader: streams a DESC_DIM x DESC_DIM template descriptor,
// LANES pixels per word, into a double-buffered bank of log2 registers.
// The shadow bank fills while the active bank feeds the PE grid; a full
// shadow becomes active only when the correlator reports idle.
//   clk, rst       : clock, async active-high reset
//   clear          : sync abort of a partial (or complete, unswapped) load
//   in_valid/in_ready/in_data : word stream, lane 0 in the MSB slice
//   consumer_idle  : swap permitted this cycle
//   desc_out       : active bank, element r*DESC_DIM+c at [idx*33 +: 33]
//   desc_valid     : active bank holds a full descriptor
//   swap_pulse     : one cycle high, the cycle after a swap
import ncc_pkg::*;

module ncc_desc_loader #(
    parameter int DESC_DIM = 16,
    parameter int LANES    = 4,
    parameter int PIX_W    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*PIX_W-1:0]            in_data,
    input  logic                              consumer_idle,
    output logic [DESC_DIM*DESC_DIM*LOG_W-1:0] desc_out,
    output logic                              desc_valid,
    output logic                              swap_pulse
);

    localparam int N_ELEM = DESC_DIM * DESC_DIM;
    localparam int N_GRP  = DESC_DIM / LANES;
    localparam int GRP_W  = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam int ROW_W  = (DESC_DIM > 1) ? $clog2(DESC_DIM) : 1;
    localparam int BANK_W = N_ELEM * LOG_W;

    if (DESC_DIM % LANES != 0) begin : g_bad_lanes
        $error("ncc_desc_loader: DESC_DIM must be a multiple of LANES");
    end
    if (PIX_W < 1 || PIX_W > 31) begin : g_bad_pix_w
        $error("ncc_desc_loader: PIX_W must be in 1..31");
    end

    ld_state_t        state;
    logic [ROW_W-1:0] row;
    logic [GRP_W-1:0] col_grp;
    logic             active_sel;
    logic [BANK_W-1:0] bank [2];
    log2_t            lane_log [LANES];
    logic             last_grp;
    logic             last_row;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pixel_log2 #(.PIX_W(PIX_W)) u_log2 (
            .pix     (in_data[(LANES-l)*PIX_W-1 -: PIX_W]),
            .log_val (lane_log[l])
        );
    end

    assign in_ready = (state == ST_LOAD);
    assign last_grp = (col_grp == GRP_W'(N_GRP - 1));
    assign last_row = (row == ROW_W'(DESC_DIM - 1));
    assign desc_out = active_sel ? bank[1] : bank[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_LOAD;
            row        <= '0;
            col_grp    <= '0;
            active_sel <= 1'b0;
            desc_valid <= 1'b0;
            swap_pulse <= 1'b0;
            bank[0]    <= '0;
            bank[1]    <= '0;
        end else begin
            swap_pulse <= 1'b0;
            if (clear) begin
                // Abort wins over transfers and over a pending swap; the
                // active bank is untouched.
                state   <= ST_LOAD;
                row     <= '0;
                col_grp <= '0;
            end else if (state == ST_LOAD) begin
                if (in_valid) begin
                    // Only the shadow bank (!active_sel) is ever written.
                    for (int l = 0; l < LANES; l++) begin
                        bank[~active_sel][(int'(row) * DESC_DIM + int'(col_grp) * LANES + l) * LOG_W +: LOG_W]
                            <= lane_log[l];
                    end
                    if (last_grp) begin
                        col_grp <= '0;
                        if (last_row) begin
                            row   <= '0;
                            state <= ST_FULL;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col_grp <= col_grp + 1'b1;
                    end
                end
            end else if (consumer_idle) begin
                active_sel <= ~active_sel;
                desc_valid <= 1'b1;
                swap_pulse <= 1'b1;
                state      <= ST_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_ncc_desc_loader.sv
// tb_ncc_desc_loader: self-checking bench for ncc_desc_loader.
// A 16x16/4-lane/8-bit instance carries most of the checks; an
// 8x8/2-lane/12-bit instance reruns the basic load and conversion.
module tb_ncc_desc_loader;

    localparam int DIM  = 16;
    localparam int LN   = 4;
    localparam int PW   = 8;
    localparam int NE   = DIM * DIM;
    localparam int NW   = NE / LN;
    localparam int DIM2 = 8;
    localparam int LN2  = 2;
    localparam int PW2  = 12;
    localparam int NE2  = DIM2 * DIM2;
    localparam int NW2  = NE2 / LN2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [LN*PW-1:0]      in_data;
    logic                  consumer_idle;
    logic [NE*33-1:0]      desc_out;
    logic                  desc_valid;
    logic                  swap_pulse;

    logic                  s_clear;
    logic                  s_in_valid;
    logic                  s_in_ready;
    logic [LN2*PW2-1:0]    s_in_data;
    logic                  s_idle;
    logic [NE2*33-1:0]     s_desc_out;
    logic                  s_desc_valid;
    logic                  s_swap_pulse;

    always #5 clk = ~clk;

    ncc_desc_loader #(.DESC_DIM(DIM), .LANES(LN), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .consumer_idle(consumer_idle),
        .desc_out(desc_out), .desc_valid(desc_valid), .swap_pulse(swap_pulse)
    );

    ncc_desc_loader #(.DESC_DIM(DIM2), .LANES(LN2), .PIX_W(PW2)) dut2 (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_data(s_in_data), .consumer_idle(s_idle),
        .desc_out(s_desc_out), .desc_valid(s_desc_valid), .swap_pulse(s_swap_pulse)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] exp_shadow [NE];
    logic [32:0] exp_active [NE];
    int          m_word;
    int          pix_q[$];

    typedef struct {
        int          pix;
        logic [32:0] expv;
    } vec_t;
    vec_t tbl [8];

    // Reference conversion from the number itself: largest power of two not
    // above p gives the exponent, the remainder scaled to 27 bits the fraction.
    function automatic logic [32:0] ref_log2(input int p);
        int     e;
        longint pw;
        longint f;
        if (p <= 0) return '0;
        e  = 0;
        pw = 1;
        while (pw * 2 <= longint'(p)) begin
            pw = pw * 2;
            e++;
        end
        f = (longint'(p) - pw) * (longint'(1) << (27 - e));
        return {1'b0, 5'(e), 27'(f)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_bank(input string name);
        int bad = -1;
        for (int i = 0; i < NE; i++) begin
            if (bad < 0 && desc_out[i*33 +: 33] !== exp_active[i]) bad = i;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: elem %0d got %0h expected %0h", name, bad,
                     desc_out[bad*33 +: 33], exp_active[bad]);
        end
    endtask

    task automatic fill_rand(input int nwords);
        for (int i = 0; i < nwords * LN; i++) pix_q.push_back(int'($urandom_range(0, 255)));
    endtask

    // Offer words until n have been accepted; every accepted word lands in
    // the model shadow in arrival order.
    task automatic send_words(input int n, input bit rand_valid);
        int                done = 0;
        int                cyc = 0;
        bit                v;
        logic [LN*PW-1:0]  d;
        while (done < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            d = '0;
            for (int l = 0; l < LN; l++) d[(LN-l)*PW-1 -: PW] = PW'(pix_q[l]);
            in_valid = v;
            in_data  = d;
            check("in_ready_load", 64'(in_ready), 64'(1));
            if (v) begin
                for (int l = 0; l < LN; l++) exp_shadow[m_word*LN + l] = ref_log2(pix_q.pop_front());
                m_word++;
                done++;
            end
        end
        if (done < n) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got %0d words expected %0d", done, n);
        end
    endtask

    // Called right after the last word was offered: checks cycle N (FULL),
    // and if consumer_idle is high, the swap in cycle N+1.
    task automatic finish_load(input bit idle);
        @(negedge clk);
        in_valid = 1'b0;
        m_word   = 0;
        check("in_ready_full", 64'(in_ready), 64'(0));
        check("swap_early", 64'(swap_pulse), 64'(0));
        check_bank("active_held_full");
        if (idle) begin
            @(negedge clk);
            exp_active = exp_shadow;
            check("swap_pulse", 64'(swap_pulse), 64'(1));
            check("in_ready_after_swap", 64'(in_ready), 64'(1));
            check("desc_valid", 64'(desc_valid), 64'(1));
            check_bank("swapped_bank");
            @(negedge clk);
            check("swap_one_cycle", 64'(swap_pulse), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] exp2 [NE2];
        int          p2 [NE2];
        int          bad;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; consumer_idle = 1'b0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_idle = 1'b0;
        m_word = 0;
        for (int i = 0; i < NE; i++) begin
            exp_shadow[i] = '0;
            exp_active[i] = '0;
        end

        tbl[0] = '{pix: 0,   expv: {1'b0, 5'd0, 27'h0}};
        tbl[1] = '{pix: 1,   expv: {1'b0, 5'd0, 27'h0}};
        tbl[2] = '{pix: 200, expv: {1'b0, 5'd7, 27'h4800000}};
        tbl[3] = '{pix: 255, expv: {1'b0, 5'd7, 27'h7F00000}};
        tbl[4] = '{pix: 128, expv: {1'b0, 5'd7, 27'h0}};
        tbl[5] = '{pix: 3,   expv: {1'b0, 5'd1, 27'h4000000}};
        tbl[6] = '{pix: 2,   expv: {1'b0, 5'd1, 27'h0}};
        tbl[7] = '{pix: 254, expv: {1'b0, 5'd7, 27'h7E00000}};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_desc_valid", 64'(desc_valid), 64'(0));
        check("rst_swap_pulse", 64'(swap_pulse), 64'(0));
        check_bank("rst_bank");
        rst = 1'b0;

        // Sequential pixels, consumer idle throughout
        consumer_idle = 1'b1;
        for (int k = 0; k < NE; k++) pix_q.push_back((k % 255) + 1);
        send_words(NW, 1'b0);
        finish_load(1'b1);

        // Conversion table: first lanes carry the table pixels
        for (int i = 0; i < 8; i++) pix_q.push_back(tbl[i].pix);
        fill_rand(NW - 2);
        send_words(NW, 1'b0);
        finish_load(1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tbl_pix_%0d", tbl[i].pix), 64'(desc_out[i*33 +: 33]), 64'(tbl[i].expv));
        end

        // Swap held off while the consumer is busy
        consumer_idle = 1'b0;
        fill_rand(NW);
        send_words(NW, 1'b0);
        finish_load(1'b0);
        repeat (10) begin
            @(negedge clk);
            check("busy_in_ready", 64'(in_ready), 64'(0));
            check("busy_no_swap", 64'(swap_pulse), 64'(0));
            check_bank("busy_hold_old");
        end
        consumer_idle = 1'b1;
        @(negedge clk);
        exp_active = exp_shadow;
        check("late_swap_pulse", 64'(swap_pulse), 64'(1));
        check("late_in_ready", 64'(in_ready), 64'(1));
        check_bank("late_swap_bank");

        // Random valid gaps: only handshaken words count
        fill_rand(NW);
        send_words(NW, 1'b1);
        finish_load(1'b1);

        // Clear after 20 words, with a valid word presented alongside clear
        fill_rand(20);
        send_words(20, 1'b0);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = LN*PW'($urandom);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        m_word   = 0;
        check("clear_in_ready", 64'(in_ready), 64'(1));
        check("clear_desc_valid", 64'(desc_valid), 64'(1));
        check_bank("clear_active_intact");
        fill_rand(NW);
        send_words(NW, 1'b0);
        finish_load(1'b1);

        // Clear in FULL, same cycle as the swap condition: no swap
        consumer_idle = 1'b0;
        fill_rand(NW);
        send_words(NW, 1'b0);
        finish_load(1'b0);
        clear         = 1'b1;
        consumer_idle = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_full_no_swap", 64'(swap_pulse), 64'(0));
        check("clear_full_in_ready", 64'(in_ready), 64'(1));
        check_bank("clear_full_bank");
        @(negedge clk);
        check("clear_full_still_no_swap", 64'(swap_pulse), 64'(0));
        check_bank("clear_full_bank_later");

        // Async reset mid-load
        fill_rand(10);
        send_words(10, 1'b0);
        check("pre_rst_desc_valid", 64'(desc_valid), 64'(1));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NE; i++) exp_active[i] = '0;
        m_word = 0;
        check("async_rst_desc_valid", 64'(desc_valid), 64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        check("async_rst_swap", 64'(swap_pulse), 64'(0));
        check_bank("async_rst_bank");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 8x8, 2 lanes, 12-bit instance
        for (int k = 0; k < NE2; k++) p2[k] = int'($urandom_range(0, 4095));
        p2[0] = 4095; p2[1] = 0; p2[2] = 1; p2[3] = 2048; p2[4] = 200;
        for (int k = 0; k < NE2; k++) exp2[k] = ref_log2(p2[k]);
        s_idle = 1'b1;
        for (int w = 0; w < NW2; w++) begin
            @(negedge clk);
            check("s_in_ready_load", 64'(s_in_ready), 64'(1));
            s_in_valid = 1'b1;
            s_in_data  = {12'(p2[2*w]), 12'(p2[2*w + 1])};
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        check("s_in_ready_full", 64'(s_in_ready), 64'(0));
        check("s_swap_early", 64'(s_swap_pulse), 64'(0));
        check("s_desc_valid_before", 64'(s_desc_valid), 64'(0));
        @(negedge clk);
        check("s_swap_pulse", 64'(s_swap_pulse), 64'(1));
        check("s_desc_valid", 64'(s_desc_valid), 64'(1));
        bad = -1;
        for (int k = 0; k < NE2; k++) begin
            if (bad < 0 && s_desc_out[k*33 +: 33] !== exp2[k]) bad = k;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL s_bank: elem %0d got %0h expected %0h", bad, s_desc_out[bad*33 +: 33], exp2[bad]);
        end
        check("s_pix_4095", 64'(s_desc_out[0 +: 33]), 64'({1'b0, 5'd11, 27'h7FF0000}));
        check("s_pix_0", 64'(s_desc_out[33 +: 33]), 64'(0));
        check("s_pix_2048", 64'(s_desc_out[3*33 +: 33]), 64'({1'b0, 5'd11, 27'h0}));
        check("s_pix_200", 64'(s_desc_out[4*33 +: 33]), 64'({1'b0, 5'd7, 27'h4800000}));
        @(negedge clk);
        check("s_swap_one_cycle", 64'(s_swap_pulse), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
